// File: rtl/sa_autosa_csb_pkg.sv
// Shared CSB definitions for the CMAC register-access arbiters.
// Holds payload widths, request field positions and the helper that decides
// whether a request will be answered by a response on the cmac2csb channel.
package sa_autosa_csb_pkg;

  localparam int CSB_REQ_PD_W        = 63;
  localparam int CSB_RSP_PD_W        = 34;
  localparam int CSB_REQ_WRITE_BIT   = 54;
  localparam int CSB_REQ_NPOSTED_BIT = 55;

  typedef logic [CSB_REQ_PD_W-1:0] csb_req_pd_t;
  typedef logic [CSB_RSP_PD_W-1:0] csb_rsp_pd_t;

  // Reads and non-posted writes are answered; posted writes are fire-and-forget.
  function automatic logic csb_needs_resp(input csb_req_pd_t pd);
    return !pd[CSB_REQ_WRITE_BIT] || pd[CSB_REQ_NPOSTED_BIT];
  endfunction

endpackage

// File: rtl/sa_autosa_csb_owner_fifo.sv
// Owner FIFO: records which requester issued each response-bearing CSB
// request so that in-order responses can be steered back to it.
// Ports:
//   autosa_core_clk / autosa_core_rstn : clock, async active-low reset
//   push, push_id                      : enqueue the requester id
//   pop                                : dequeue the head entry
//   head_id                            : id at the head of the queue
//   empty, full                        : occupancy flags
//   cnt                                : number of stored entries
// The caller guarantees no push when full and no pop when empty.
module sa_autosa_csb_owner_fifo
  import sa_autosa_csb_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int OST_AW    = $clog2(OST_DEPTH)
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rstn,
  input  logic              push,
  input  logic              push_id,
  input  logic              pop,
  output logic              head_id,
  output logic              empty,
  output logic              full,
  output logic [OST_AW:0]   cnt
);

  logic [OST_DEPTH-1:0] mem;
  logic [OST_AW-1:0]    wr_ptr;
  logic [OST_AW-1:0]    rd_ptr;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge autosa_core_clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head_id = mem[rd_ptr];
  assign empty   = (cnt == '0);
  // Depth is a power of two, so the count MSB alone marks "full".
  assign full    = cnt[OST_AW];

endmodule

// File: rtl/sa_autosa_csb_arb.sv
// Two-requester CSB arbiter in front of the CMAC register-access path.
// Port 0 is the host CSB master, port 1 the on-chip config sequencer. Granted
// requests go out through a single output register; the owner of every
// response-bearing request is queued so that in-order responses from
// cmac2csb are routed back to the right requester one cycle later.
// Ports:
//   autosa_core_clk / autosa_core_rstn : clock, async active-low reset
//   req{0,1}_pvld/prdy/pd              : requester request channels
//   csb2cmac_req_dst_pvld/prdy/pd      : shared downstream request channel
//   cmac2csb_resp_valid/pd             : downstream responses (no backpressure)
//   resp{0,1}_valid/pd                 : routed responses
//   ost_cnt                            : outstanding response-bearing requests
//   orphan_err                         : sticky, response with nothing outstanding
module sa_autosa_csb_arb
  import sa_autosa_csb_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter int OST_AW    = $clog2(OST_DEPTH)
) (
  input  logic                    autosa_core_clk,
  input  logic                    autosa_core_rstn,
  input  logic                    req0_pvld,
  output logic                    req0_prdy,
  input  logic [CSB_REQ_PD_W-1:0] req0_pd,
  input  logic                    req1_pvld,
  output logic                    req1_prdy,
  input  logic [CSB_REQ_PD_W-1:0] req1_pd,
  output logic                    csb2cmac_req_dst_pvld,
  input  logic                    csb2cmac_req_dst_prdy,
  output logic [CSB_REQ_PD_W-1:0] csb2cmac_req_dst_pd,
  input  logic                    cmac2csb_resp_valid,
  input  logic [CSB_RSP_PD_W-1:0] cmac2csb_resp_pd,
  output logic                    resp0_valid,
  output logic [CSB_RSP_PD_W-1:0] resp0_pd,
  output logic                    resp1_valid,
  output logic [CSB_RSP_PD_W-1:0] resp1_pd,
  output logic [OST_AW:0]         ost_cnt,
  output logic                    orphan_err
);

  logic        dst_vld_p1;
  csb_req_pd_t dst_pd_p1;
  logic        last_gnt;
  logic        resp0_vld_p1;
  logic        resp1_vld_p1;
  csb_rsp_pd_t resp_pd_p1;

  logic can_load;
  logic needs0, needs1;
  logic elig0, elig1;
  logic gnt0, gnt1, grant;
  logic push, push_id, pop;
  logic fifo_empty, fifo_full, head_id;

  // Arbitration is purely a function of requests, output-register state and
  // the registered outstanding count, so response arrival never reaches prdy.
  always_comb begin
    needs0   = csb_needs_resp(req0_pd);
    needs1   = csb_needs_resp(req1_pd);
    can_load = !dst_vld_p1 || csb2cmac_req_dst_prdy;
    elig0    = req0_pvld && (!needs0 || !fifo_full);
    elig1    = req1_pvld && (!needs1 || !fifo_full);
    // last_gnt == 1 means port 1 was served last, so port 0 wins a tie.
    // Grants are held off while reset is asserted.
    gnt0     = autosa_core_rstn && can_load && elig0 && (last_gnt || !elig1);
    gnt1     = autosa_core_rstn && can_load && elig1 && (!last_gnt || !elig0);
    grant    = gnt0 || gnt1;
    push     = (gnt0 && needs0) || (gnt1 && needs1);
    push_id  = gnt1;
    pop      = cmac2csb_resp_valid && !fifo_empty;
  end

  assign req0_prdy = gnt0;
  assign req1_prdy = gnt1;

  sa_autosa_csb_owner_fifo #(
    .OST_DEPTH (OST_DEPTH),
    .OST_AW    (OST_AW)
  ) u_owner_fifo (
    .autosa_core_clk  (autosa_core_clk),
    .autosa_core_rstn (autosa_core_rstn),
    .push             (push),
    .push_id          (push_id),
    .pop              (pop),
    .head_id          (head_id),
    .empty            (fifo_empty),
    .full             (fifo_full),
    .cnt              (ost_cnt)
  );

  // ---- stage p1: request output register and routed response register ----
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      dst_vld_p1   <= 1'b0;
      last_gnt     <= 1'b1;
      resp0_vld_p1 <= 1'b0;
      resp1_vld_p1 <= 1'b0;
      orphan_err   <= 1'b0;
    end else begin
      if (can_load) dst_vld_p1 <= grant;
      if (grant)    last_gnt   <= gnt1;
      resp0_vld_p1 <= pop && !head_id;
      resp1_vld_p1 <= pop &&  head_id;
      if (cmac2csb_resp_valid && fifo_empty) orphan_err <= 1'b1;
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (grant) dst_pd_p1  <= gnt1 ? req1_pd : req0_pd;
    if (pop)   resp_pd_p1 <= cmac2csb_resp_pd;
  end

  assign csb2cmac_req_dst_pvld = dst_vld_p1;
  assign csb2cmac_req_dst_pd   = dst_pd_p1;
  assign resp0_valid           = resp0_vld_p1;
  assign resp1_valid           = resp1_vld_p1;
  assign resp0_pd              = resp_pd_p1;
  assign resp1_pd              = resp_pd_p1;

endmodule
